// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Byte-wide memory bus between a requester (mem_access_unit) and the memory
// arbiter.
//
// Handshake: mem_req_o is the valid and grant_i is the ready. A byte access
// transfers at a rising edge where both are high. While mem_req_o is high and
// grant_i is low, the requester holds mem_we_o, mem_addr_o and mem_wdata_o
// stable. For a granted read, mem_rdata_i carries the byte during the cycle
// after the grant and is sampled at the end of that cycle.
//
// Signals:
//   mem_req_o    requester -> arbiter  access valid
//   mem_we_o     requester -> arbiter  1 = write
//   mem_addr_o   requester -> arbiter  byte address
//   mem_wdata_o  requester -> arbiter  write byte
//   grant_i      arbiter -> requester  access accepted this cycle
//   mem_rdata_i  arbiter -> requester  read byte, cycle after read grant
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              grant_i;
    logic [7:0]        mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  grant_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output grant_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Requester-side sequencer for the byte-wide memory bus. One MEM-stage
// load/store of byte, half or word size becomes a sequence of single-byte
// little-endian bus accesses. Read bytes are assembled and sign/zero
// extended. Completion is signalled with a one-cycle done_o pulse.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_i         MEM-stage request (level), sampled only while idle
//   we_i          1 = store, 0 = load
//   size_i        00 byte, 01 half, 10/11 word
//   sign_i        loads: 1 = sign-extend, 0 = zero-extend
//   addr_i        base byte address (unaligned allowed, wraps)
//   wdata_i       store data, low bytes used
//   bus           byte bus to the arbiter (master side)
//   busy_o        unit is not idle
//   done_o        one-cycle completion pulse
//   rdata_o       extended load result, held until the next load completes
//   dbg_state_o   current FSM state (0 IDLE, 1 ACCESS, 2 RLAST, 3 DONE)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [1:0]          size_i,
    input  logic                sign_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    mem_access_unit_if.master   bus,
    output logic                busy_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RLAST  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pend_q, pend_d;
    logic [1:0]          pidx_q, pidx_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_wdata;
    logic [2:0]          last_idx;

    // Index of the final byte of the latched access.
    always_comb begin
        case (size_q)
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd1;
            default: last_idx = 3'd3;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        sign_d    = sign_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pend_d    = 1'b0;
        pidx_d    = pidx_q;
        buf_d     = buf_q;
        rdata_d   = rdata_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        done_o    = 1'b0;

        // The byte granted last cycle is on mem_rdata_i now, whatever the
        // state; a grant at this same edge re-arms pend_d below.
        if (pend_q) begin
            buf_d[{pidx_q, 3'b000} +: 8] = bus.mem_rdata_i;
        end

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    sign_d  = sign_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = 3'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = addr_q + ADDR_W'(cnt_q);
                if (we_q) begin
                    mem_wdata = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                end
                if (bus.grant_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (!we_q) begin
                        pend_d = 1'b1;
                        pidx_d = cnt_q[1:0];
                    end
                    if (cnt_q == last_idx) begin
                        state_d = we_q ? S_DONE : S_RLAST;
                    end
                end
            end
            S_RLAST: begin
                // buf_d already contains the last byte captured at this edge.
                case (size_q)
                    2'b00:   rdata_d = {{24{sign_q & buf_d[7]}},  buf_d[7:0]};
                    2'b01:   rdata_d = {{16{sign_q & buf_d[15]}}, buf_d[15:0]};
                    default: rdata_d = buf_d;
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pend_q  <= 1'b0;
            pidx_q  <= 2'd0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign busy_o          = (state_q != S_IDLE);
    assign rdata_o         = rdata_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_i, we_i, sign_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o;
    logic [31:0] rdata_o;
    logic [1:0]  dbg_state_o;

    mem_access_unit_if #(.ADDR_W(32)) bus_if ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .sign_i      (sign_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .bus         (bus_if),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    // Expected bus accesses: {we, addr[31:0], wdata[7:0]}
    logic [40:0] exp_q[$];
    bit [7:0]    ref_mem[bit [31:0]];   // reference model memory
    bit [7:0]    bus_mem[bit [31:0]];   // memory seen by the bus responder
    int          grant_mode;            // 0 always, 1 random, 2 hold before byte 2
    int          hold_left;
    int          acc_idx;
    bit          rd_pend;
    logic [31:0] rd_addr;
    logic [31:0] last_load;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [7:0] init_byte(input bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic bit [7:0] ref_rd(input bit [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic bit [7:0] bus_rd(input bit [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_byte(a);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    // Little-endian gather of n bytes, then extension above bit 8n-1.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
        logic [63:0] v;
        int n;
        n = nbytes(s);
        v = 64'd0;
        for (int k = 0; k < n; k++) begin
            v = v | (64'(ref_rd(a + 32'(k))) << (8 * k));
        end
        if (sg && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        return v[31:0];
    endfunction

    // ---------------- bus responder (one call per negedge) ----------------
    task automatic bus_step();
        logic        g;
        logic [40:0] e;
        if (rd_pend) begin
            bus_if.mem_rdata_i = bus_rd(rd_addr);
            rd_pend = 1'b0;
        end else begin
            bus_if.mem_rdata_i = 8'($urandom);
        end
        case (grant_mode)
            0: g = 1'b1;
            1: g = 1'($urandom_range(0, 1));
            default: begin
                if (acc_idx == 2 && hold_left > 0) begin
                    g = 1'b0;
                    hold_left--;
                end else begin
                    g = 1'b1;
                end
            end
        endcase
        bus_if.grant_i = g;
        if (bus_if.mem_req_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 32'(bus_if.mem_req_o), 32'd0);
            end else begin
                e = exp_q[0];
                if (g) begin
                    void'(exp_q.pop_front());
                    check("bus_we", 32'(bus_if.mem_we_o), 32'(e[40]));
                    check("bus_addr", bus_if.mem_addr_o, e[39:8]);
                    check("bus_wdata", 32'(bus_if.mem_wdata_o), 32'(e[7:0]));
                    if (e[40]) begin
                        bus_mem[bus_if.mem_addr_o] = bus_if.mem_wdata_o;
                    end else begin
                        rd_pend = 1'b1;
                        rd_addr = bus_if.mem_addr_o;
                    end
                    acc_idx++;
                end else begin
                    check("hold_addr", bus_if.mem_addr_o, e[39:8]);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus_step();
    endtask

    // ---------------- driver ----------------
    // Called from an IDLE-cycle negedge; returns in the IDLE cycle after done.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input int exp_lat);
        int          n;
        int          c;
        logic [31:0] exp_r;
        n = nbytes(sz);
        c = 0;
        acc_idx = 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({we, a + 32'(k), we ? wd[8 * k +: 8] : 8'h00});
        end
        if (we) begin
            for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = wd[8 * k +: 8];
            exp_r = last_load;
        end else begin
            exp_r = ref_load(a, sz, sg);
        end
        req_i = 1'b1; we_i = we; size_i = sz; sign_i = sg; addr_i = a; wdata_i = wd;
        do begin
            tick();
            c++;
            if (c == 1) begin
                check("busy_after_accept", 32'(busy_o), 32'd1);
                // Inputs must be ignored while busy.
                we_i = 1'($urandom); size_i = 2'($urandom); sign_i = 1'($urandom);
                addr_i = $urandom; wdata_i = $urandom;
            end
        end while (done_o !== 1'b1 && c < 200);
        check("done_seen", 32'(done_o), 32'd1);
        if (exp_lat >= 0) check("latency", 32'(c), 32'(exp_lat));
        check("rdata", rdata_o, exp_r);
        check("busy_in_done", 32'(busy_o), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (!we) last_load = exp_r;
        req_i = 1'b0;
        tick();
        check("done_pulse_width", 32'(done_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("rdata_hold", rdata_o, last_load);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sign_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        bus_if.grant_i = 1'b0; bus_if.mem_rdata_i = 8'h00;
        grant_mode = 0; hold_left = 0; acc_idx = 0;
        rd_pend = 1'b0; rd_addr = '0; last_load = '0;

        // Reset values
        #1;
        check("rst_mem_req",   32'(bus_if.mem_req_o),   32'd0);
        check("rst_mem_we",    32'(bus_if.mem_we_o),    32'd0);
        check("rst_mem_addr",  bus_if.mem_addr_o,       32'd0);
        check("rst_mem_wdata", 32'(bus_if.mem_wdata_o), 32'd0);
        check("rst_busy",      32'(busy_o),             32'd0);
        check("rst_done",      32'(done_o),             32'd0);
        check("rst_rdata",     rdata_o,                 32'd0);
        check("rst_state",     32'(dbg_state_o),        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Word store, continuous grant
        run_access(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5);
        check("store_ram_103", 32'(bus_rd(32'h103)), 32'h0000_00DE);

        // Signed / unsigned byte load of 0x80
        ref_mem[32'h200] = 8'h80; bus_mem[32'h200] = 8'h80;
        run_access(1'b0, 2'b00, 1'b1, 32'h0000_0200, 32'h0, 3);
        check("sbyte_value", rdata_o, 32'hFFFF_FF80);
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 3);
        check("ubyte_value", rdata_o, 32'h0000_0080);

        // Unaligned half load across 0x3FF/0x400
        ref_mem[32'h3FF] = 8'h01; bus_mem[32'h3FF] = 8'h01;
        ref_mem[32'h400] = 8'h80; bus_mem[32'h400] = 8'h80;
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_03FF, 32'h0, 4);
        check("uhalf_value", rdata_o, 32'h0000_8001);
        run_access(1'b0, 2'b01, 1'b1, 32'h0000_03FF, 32'h0, 4);
        check("shalf_value", rdata_o, 32'hFFFF_8001);

        // Word load with two ungranted cycles before byte 2
        grant_mode = 2; hold_left = 2;
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 8);
        check("hold_consumed", 32'(hold_left), 32'd0);
        grant_mode = 0;

        // Asynchronous reset in the middle of a word load, after two grants
        acc_idx = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 32'h500 + 32'(k), 8'h00});
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; sign_i = 1'b0; addr_i = 32'h500;
        tick();
        tick();
        req_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req",  32'(bus_if.mem_req_o), 32'd0);
        check("midrst_mem_addr", bus_if.mem_addr_o,     32'd0);
        check("midrst_busy",     32'(busy_o),           32'd0);
        check("midrst_state",    32'(dbg_state_o),      32'd0);
        bus_if.grant_i = 1'b0;
        exp_q.delete();
        rd_pend = 1'b0;
        last_load = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_rdata", rdata_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", 32'(done_o), 32'd0);
        end
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 6);

        // Back-to-back store then load
        run_access(1'b1, 2'b10, 1'b0, 32'h0000_0700, 32'h1234_5678, 5);
        run_access(1'b0, 2'b10, 1'b1, 32'h0000_0700, 32'h0, 6);
        check("b2b_load_value", rdata_o, 32'h1234_5678);

        // Address wrap-around
        run_access(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 5);
        check("wrap_ram_0", 32'(bus_rd(32'h0)), 32'h0000_00B2);
        run_access(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0, 6);
        check("wrap_load_value", rdata_o, 32'hA1B2_C3D4);

        // Randomized accesses with random grants
        grant_mode = 1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else a = 32'h0000_1000 + 32'($urandom_range(0, 31));
            run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), a, $urandom, -1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
